enemy_formation_ctrl: RTL and testbench
=======================================

Name: enemy_formation_ctrl

Overview:
Upstream controller for the 3x8 enemy grid. It produces the per-column X and per-row Y positions plus a per-enemy alive mask, which the enemy sprite instances consume. It marches the formation left and right, steps it down at the screen edges, and speeds up as enemies die. It also detects player-bullet hits, producing the hit pulse that feeds the player-bullet block, along with a score and game-end flags.

Parameters:
COLS, 8, enemy columns
ROWS, 3, enemy rows
X0, 60, initial base X (left edge of column 0)
Y0, 40, initial base Y (top edge of row 0)
DX, 64, column pitch in pixels
DY, 50, row pitch in pixels
EN_W, 32, enemy box width
EN_H, 24, enemy box height
STEP_X, 4, horizontal step per move
STEP_Y, 16, vertical step at an edge
X_MAX, 639, rightmost visible pixel
FLOOR_Y, 420, invasion line
PTS, 10, score per kill

Ports:
clk  in  1  system clock
reset  in  1  async active-high reset
frame_start  in  1  one-cycle pulse at start of vertical blank
bullet_active  in  1  player bullet in flight
bullet_x  in  11  bullet pixel X
bullet_y  in  11  bullet pixel Y
base_x  out  10  X of column 0; column c is at base_x + c*DX
base_y  out  10  Y of row 0; row r is at base_y + r*DY
alive  out  24  bit r*COLS+c set when enemy (r,c) is alive
hit  out  1  one-cycle pulse on a kill
score  out  16  accumulated score
invaded  out  1  sticky; formation reached FLOOR_Y
cleared  out  1  sticky; all enemies dead

Behaviour:
- Reset: clk and reset as decided above; reset is asynchronous, active-high. On reset: base_x=X0, base_y=Y0, alive=all ones, dir=right, frame_cnt=0, hit=0, score=0, invaded=0, cleared=0, hit_lock=0, state=RUN.
- Reset mid-operation: all registers return to the reset values immediately, independent of clk.
- States: RUN, INVADED, CLEARED. INVADED and CLEARED are terminal until reset. No moves or hits occur in terminal states; outputs are frozen.
- Move period: period = 1 + popcount(alive)/4 (integer division), in frames. With 24 alive, period=7; with 1-3 alive, period=1.
- Move counter: frame_cnt increments on each frame_start. When frame_cnt+1 >= period, a move event occurs and frame_cnt clears to 0.
- Move event, edge check: from the current alive mask, compute cmin and cmax (lowest and highest column with any alive enemy).
  - dir=right: if base_x + cmax*DX + EN_W + STEP_X > X_MAX, then base_y += STEP_Y, dir flips, and base_x is unchanged. Otherwise base_x += STEP_X.
  - dir=left: if base_x + cmin*DX < STEP_X, then base_y += STEP_Y, dir flips. Otherwise base_x -= STEP_X.
  - All arithmetic uses 12-bit unsigned intermediates. Outputs are truncated to 10 bits.
- Invasion: after any base_y update, if base_y + rmax*DY + EN_H >= FLOOR_Y (rmax = highest row with any alive enemy), go to INVADED and set invaded=1 on the next clk.
- Hit detection, when: evaluated every cycle in RUN with bullet_active=1 and hit_lock=0.
- Hit detection, box test: enemy (r,c) is hit if alive and base_x+c*DX <= bullet_x < base_x+c*DX+EN_W and base_y+r*DY <= bullet_y < base_y+r*DY+EN_H.
- Hit detection, multiple matches: the lowest index wins; only one kill per event.
- Kill response, on the next clk edge: the alive bit clears, hit=1 for exactly one cycle, hit_lock=1, and score += PTS, saturating at 16'hFFFF.
- hit_lock clears when bullet_active=0. While hit_lock=1, no further hits are taken, which prevents a double kill from one bullet.
- Simultaneous kill and move in the same cycle: both apply. The collision uses the pre-move base and pre-kill alive; the edge and period calculations use the pre-kill alive.
- Clear: when alive becomes 0, go to CLEARED (cleared=1 on that edge). CLEARED has priority over INVADED if both occur on the same edge.
- frame_start arriving while hit=1 is handled normally.

Decomposition:
- Shared package: COLS, ROWS, box and step constants, state enum {RUN, INVADED, CLEARED}, and an idx(r,c) helper function.
- Sub-module formation_hit_detect: purely combinational. Inputs: base_x, base_y, alive, bullet_x, bullet_y. Outputs: hit_any and a 5-bit hit_idx (lowest-index priority).
- Top-level: owns the FSM, the frame counter, the popcount, the edge logic and the score.

Test Plan:
1. Reset release: after reset with no frame_start -> base_x=60, base_y=40, alive=24'hFFFFFF, score=0, all flags 0.
2. March: drive 7 frame_start pulses -> base_x=64 after the 7th and unchanged after pulses 1-6. Kill 20 enemies, then 2 frame_start pulses -> the move happens every 2nd frame (4 alive gives period=2).
3. Edge bounce: full grid marching right. At the move where base_x+448+32+4 > 639 -> base_y=56, dir=left, base_x unchanged. The next move -> base_x decreases by 4.
4. Hit: bullet_active=1, bullet=(70,45) -> the next cycle shows hit=1 for one cycle, alive[0]=0, score=10. Bullet held at the same point for 10 cycles -> no second hit. bullet_active=0, then 1 with the bullet at enemy 1 -> alive[1]=0, score=20.
5. Invasion: force base_y by moving until base_y + 2*50 + 24 >= 420 -> invaded=1 and moves stop. Subsequent hits are ignored.
6. Clear: kill all 24 enemies in sequence -> cleared=1 and score=240. Asserting reset mid-game restores all reset values immediately.

Source files
------------

// File: rtl/enemy_formation_ctrl_pkg.sv
// Shared constants, state encodings and index helper for the 3x8 enemy formation.
package enemy_formation_ctrl_pkg;

    localparam int unsigned COLS    = 8;
    localparam int unsigned ROWS    = 3;
    localparam int unsigned N_EN    = COLS * ROWS;
    localparam int unsigned X0      = 60;
    localparam int unsigned Y0      = 40;
    localparam int unsigned DX      = 64;
    localparam int unsigned DY      = 50;
    localparam int unsigned EN_W    = 32;
    localparam int unsigned EN_H    = 24;
    localparam int unsigned STEP_X  = 4;
    localparam int unsigned STEP_Y  = 16;
    localparam int unsigned X_MAX   = 639;
    localparam int unsigned FLOOR_Y = 420;
    localparam int unsigned PTS     = 10;

    localparam int unsigned POS_W   = 10;
    localparam int unsigned COORD_W = 11;
    localparam int unsigned CALC_W  = 12;
    localparam int unsigned IDX_W   = 5;
    localparam int unsigned COL_W   = 3;
    localparam int unsigned ROW_W   = 2;
    localparam int unsigned POP_W   = 5;
    localparam int unsigned CNT_W   = 3;
    localparam int unsigned SCORE_W = 16;

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_INVADED = 2'd1;
    localparam logic [1:0] ST_CLEARED = 2'd2;

    function automatic logic [IDX_W-1:0] idx(input int unsigned r, input int unsigned c);
        return IDX_W'(r * COLS + c);
    endfunction

endpackage

// File: rtl/enemy_formation_if.sv
// Bullet/frame inputs and formation state outputs of the enemy formation controller.
interface enemy_formation_if;
    import enemy_formation_ctrl_pkg::*;

    logic                 frame_start;
    logic                 bullet_active;
    logic [COORD_W-1:0]   bullet_x;
    logic [COORD_W-1:0]   bullet_y;
    logic [POS_W-1:0]     base_x;
    logic [POS_W-1:0]     base_y;
    logic [N_EN-1:0]      alive;
    logic                 hit;
    logic [SCORE_W-1:0]   score;
    logic                 invaded;
    logic                 cleared;

    modport master (
        output frame_start, bullet_active, bullet_x, bullet_y,
        input  base_x, base_y, alive, hit, score, invaded, cleared
    );

    modport slave (
        input  frame_start, bullet_active, bullet_x, bullet_y,
        output base_x, base_y, alive, hit, score, invaded, cleared
    );

endinterface

// File: rtl/enemy_formation_ctrl_hit_detect.sv
// Combinational bullet-vs-enemy box test; the lowest alive index containing the bullet wins.
module formation_hit_detect
    import enemy_formation_ctrl_pkg::*;
(
    input  logic [POS_W-1:0]   base_x,
    input  logic [POS_W-1:0]   base_y,
    input  logic [N_EN-1:0]    alive,
    input  logic [COORD_W-1:0] bullet_x,
    input  logic [COORD_W-1:0] bullet_y,
    output logic               hit_any,
    output logic [IDX_W-1:0]   hit_idx
);

    logic [CALC_W-1:0] ex;
    logic [CALC_W-1:0] ey;

    // Scan from the highest index down so the lowest matching index is written last.
    always_comb begin
        hit_any = 1'b0;
        hit_idx = '0;
        ex      = '0;
        ey      = '0;
        for (int r = ROWS - 1; r >= 0; r--) begin
            for (int c = COLS - 1; c >= 0; c--) begin
                ex = CALC_W'(base_x) + CALC_W'(c * DX);
                ey = CALC_W'(base_y) + CALC_W'(r * DY);
                if (alive[idx(r, c)] &&
                    CALC_W'(bullet_x) >= ex && CALC_W'(bullet_x) < ex + CALC_W'(EN_W) &&
                    CALC_W'(bullet_y) >= ey && CALC_W'(bullet_y) < ey + CALC_W'(EN_H)) begin
                    hit_any = 1'b1;
                    hit_idx = idx(r, c);
                end
            end
        end
    end

endmodule

// File: rtl/enemy_formation_ctrl.sv
// Enemy formation controller: march/step-down movement, kill handling, score and end-of-game flags.
module enemy_formation_ctrl
    import enemy_formation_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    enemy_formation_if.slave bus
);

    logic [1:0]          state_q, state_d;
    logic [POS_W-1:0]    base_x_q, base_x_d;
    logic [POS_W-1:0]    base_y_q, base_y_d;
    logic [N_EN-1:0]     alive_q, alive_d;
    logic                dir_left_q, dir_left_d;
    logic [CNT_W-1:0]    frame_cnt_q, frame_cnt_d;
    logic                hit_q, hit_d;
    logic [SCORE_W-1:0]  score_q, score_d;
    logic                invaded_q, invaded_d;
    logic                cleared_q, cleared_d;
    logic                hit_lock_q, hit_lock_d;

    logic                hit_any;
    logic [IDX_W-1:0]    hit_idx;
    logic [POP_W-1:0]    pop;
    logic [COLS-1:0]     col_any;
    logic [ROWS-1:0]     row_any;
    logic [COL_W-1:0]    cmin, cmax;
    logic [ROW_W-1:0]    rmax;
    logic [CNT_W-1:0]    period;
    logic [CNT_W:0]      cnt_inc;
    logic                move;
    logic                bump;
    logic                invade;
    logic [CALC_W-1:0]   right_edge;
    logic [CALC_W-1:0]   left_pos;
    logic [CALC_W-1:0]   new_y;
    logic [SCORE_W:0]    score_sum;

    formation_hit_detect u_hit_detect (
        .base_x   (base_x_q),
        .base_y   (base_y_q),
        .alive    (alive_q),
        .bullet_x (bus.bullet_x),
        .bullet_y (bus.bullet_y),
        .hit_any  (hit_any),
        .hit_idx  (hit_idx)
    );

    // Occupancy summary of the pre-kill alive mask: population, column span, lowest occupied row.
    always_comb begin
        pop     = '0;
        col_any = '0;
        row_any = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (alive_q[idx(r, c)]) begin
                    pop        = pop + POP_W'(1);
                    col_any[c] = 1'b1;
                    row_any[r] = 1'b1;
                end
            end
        end
        cmin = '0;
        cmax = '0;
        rmax = '0;
        for (int c = COLS - 1; c >= 0; c--) if (col_any[c]) cmin = COL_W'(c);
        for (int c = 0; c < COLS; c++)      if (col_any[c]) cmax = COL_W'(c);
        for (int r = 0; r < ROWS; r++)      if (row_any[r]) rmax = ROW_W'(r);
    end

    // Next-state and output logic.
    always_comb begin
        state_d     = state_q;
        base_x_d    = base_x_q;
        base_y_d    = base_y_q;
        alive_d     = alive_q;
        dir_left_d  = dir_left_q;
        frame_cnt_d = frame_cnt_q;
        hit_d       = 1'b0;
        score_d     = score_q;
        invaded_d   = invaded_q;
        cleared_d   = cleared_q;
        hit_lock_d  = hit_lock_q;
        invade      = 1'b0;
        bump        = 1'b0;
        new_y       = CALC_W'(base_y_q) + CALC_W'(STEP_Y);
        score_sum   = {1'b0, score_q} + (SCORE_W + 1)'(PTS);

        period     = CNT_W'(1) + CNT_W'(pop >> 2);
        cnt_inc    = {1'b0, frame_cnt_q} + (CNT_W + 1)'(1);
        move       = bus.frame_start && (cnt_inc >= {1'b0, period});
        right_edge = CALC_W'(base_x_q) + CALC_W'(cmax) * CALC_W'(DX) + CALC_W'(EN_W + STEP_X);
        left_pos   = CALC_W'(base_x_q) + CALC_W'(cmin) * CALC_W'(DX);

        if (state_q == ST_RUN) begin
            if (bus.frame_start) frame_cnt_d = move ? '0 : CNT_W'(cnt_inc);

            if (move) begin
                bump = dir_left_q ? (left_pos < CALC_W'(STEP_X)) : (right_edge > CALC_W'(X_MAX));
                if (bump) begin
                    base_y_d   = POS_W'(new_y);
                    dir_left_d = ~dir_left_q;
                    invade     = (new_y + CALC_W'(rmax) * CALC_W'(DY) + CALC_W'(EN_H)) >= CALC_W'(FLOOR_Y);
                end else if (dir_left_q) begin
                    base_x_d = POS_W'(CALC_W'(base_x_q) - CALC_W'(STEP_X));
                end else begin
                    base_x_d = POS_W'(CALC_W'(base_x_q) + CALC_W'(STEP_X));
                end
            end

            // One kill per bullet: the lock holds until the bullet leaves flight.
            if (!bus.bullet_active) begin
                hit_lock_d = 1'b0;
            end else if (!hit_lock_q && hit_any) begin
                alive_d[hit_idx] = 1'b0;
                hit_d            = 1'b1;
                hit_lock_d       = 1'b1;
                score_d          = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
            end

            if (alive_d == '0) begin
                state_d   = ST_CLEARED;
                cleared_d = 1'b1;
            end else if (invade) begin
                state_d   = ST_INVADED;
                invaded_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_RUN;
            base_x_q    <= POS_W'(X0);
            base_y_q    <= POS_W'(Y0);
            alive_q     <= '1;
            dir_left_q  <= 1'b0;
            frame_cnt_q <= '0;
            hit_q       <= 1'b0;
            score_q     <= '0;
            invaded_q   <= 1'b0;
            cleared_q   <= 1'b0;
            hit_lock_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_x_q    <= base_x_d;
            base_y_q    <= base_y_d;
            alive_q     <= alive_d;
            dir_left_q  <= dir_left_d;
            frame_cnt_q <= frame_cnt_d;
            hit_q       <= hit_d;
            score_q     <= score_d;
            invaded_q   <= invaded_d;
            cleared_q   <= cleared_d;
            hit_lock_q  <= hit_lock_d;
        end
    end

    assign bus.base_x  = base_x_q;
    assign bus.base_y  = base_y_q;
    assign bus.alive   = alive_q;
    assign bus.hit     = hit_q;
    assign bus.score   = score_q;
    assign bus.invaded = invaded_q;
    assign bus.cleared = cleared_q;

endmodule

// File: tb/tb_enemy_formation_ctrl.sv
// Directed bench for enemy_formation_ctrl: vector table plus march, bounce, invasion and clear sequences.
module tb_enemy_formation_ctrl;

    logic clk;
    logic reset;

    enemy_formation_if ifc ();

    enemy_formation_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        fs;
        logic        ba;
        int          bx;
        int          by;
        int          e_base_x;
        int          e_base_y;
        logic [23:0] e_alive;
        logic        e_hit;
        int          e_score;
    } vec_t;

    vec_t vecs[14];

    int          n_checks;
    int          n_fail;
    int          exp_bx;
    int          exp_by;
    logic [23:0] exp_alive;
    int          exp_score;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic frame();
        ifc.frame_start = 1'b1;
        step();
        ifc.frame_start = 1'b0;
        step();
    endtask

    task automatic check_pos(input string name);
        check({name, " base_x"}, 32'(ifc.base_x), 32'(exp_bx));
        check({name, " base_y"}, 32'(ifc.base_y), 32'(exp_by));
    endtask

    // Fire one bullet at the middle of enemy i using the bench's own base position.
    task automatic kill(input int i);
        ifc.bullet_active = 1'b1;
        ifc.bullet_x      = 11'(exp_bx + (i % 8) * 64 + 5);
        ifc.bullet_y      = 11'(exp_by + (i / 8) * 50 + 5);
        exp_alive[i]      = 1'b0;
        exp_score         = exp_score + 10;
        step();
        check($sformatf("kill%0d hit", i),   32'(ifc.hit),   32'd1);
        check($sformatf("kill%0d alive", i), 32'(ifc.alive), 32'(exp_alive));
        check($sformatf("kill%0d score", i), 32'(ifc.score), 32'(exp_score));
        ifc.bullet_active = 1'b0;
        step();
        check($sformatf("kill%0d hit drop", i), 32'(ifc.hit), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ifc.frame_start   = 1'b0;
        ifc.bullet_active = 1'b0;
        ifc.bullet_x      = '0;
        ifc.bullet_y      = '0;
        step();
        step();
        #2 reset = 1'b0;
        step();
        exp_bx    = 60;
        exp_by    = 40;
        exp_alive = 24'hFFFFFF;
        exp_score = 0;
    endtask

    initial begin
        int n;
        n_checks = 0;
        n_fail   = 0;

        // March to the first move, then a kill/hold/second-kill pattern.
        for (int i = 0; i < 6; i++) vecs[i] = '{1'b1, 1'b0, 0, 0, 60, 40, 24'hFFFFFF, 1'b0, 0};
        vecs[6]  = '{1'b1, 1'b0,   0,  0, 64, 40, 24'hFFFFFF, 1'b0,  0};
        vecs[7]  = '{1'b0, 1'b0,   0,  0, 64, 40, 24'hFFFFFF, 1'b0,  0};
        vecs[8]  = '{1'b0, 1'b1,  70, 45, 64, 40, 24'hFFFFFE, 1'b1, 10};
        vecs[9]  = '{1'b0, 1'b1,  70, 45, 64, 40, 24'hFFFFFE, 1'b0, 10};
        vecs[10] = '{1'b0, 1'b1,  70, 45, 64, 40, 24'hFFFFFE, 1'b0, 10};
        vecs[11] = '{1'b0, 1'b0,  70, 45, 64, 40, 24'hFFFFFE, 1'b0, 10};
        vecs[12] = '{1'b0, 1'b1, 130, 45, 64, 40, 24'hFFFFFC, 1'b1, 20};
        vecs[13] = '{1'b0, 1'b0, 130, 45, 64, 40, 24'hFFFFFC, 1'b0, 20};

        do_reset();
        check("reset base_x",  32'(ifc.base_x),  32'd60);
        check("reset base_y",  32'(ifc.base_y),  32'd40);
        check("reset alive",   32'(ifc.alive),   32'h00FFFFFF);
        check("reset score",   32'(ifc.score),   32'd0);
        check("reset hit",     32'(ifc.hit),     32'd0);
        check("reset invaded", 32'(ifc.invaded), 32'd0);
        check("reset cleared", 32'(ifc.cleared), 32'd0);

        foreach (vecs[i]) begin
            ifc.frame_start   = vecs[i].fs;
            ifc.bullet_active = vecs[i].ba;
            ifc.bullet_x      = 11'(vecs[i].bx);
            ifc.bullet_y      = 11'(vecs[i].by);
            step();
            check($sformatf("vec%0d base_x", i), 32'(ifc.base_x), 32'(vecs[i].e_base_x));
            check($sformatf("vec%0d base_y", i), 32'(ifc.base_y), 32'(vecs[i].e_base_y));
            check($sformatf("vec%0d alive", i),  32'(ifc.alive),  32'(vecs[i].e_alive));
            check($sformatf("vec%0d hit", i),    32'(ifc.hit),    32'(vecs[i].e_hit));
            check($sformatf("vec%0d score", i),  32'(ifc.score),  32'(vecs[i].e_score));
        end
        ifc.frame_start = 1'b0;
        exp_bx    = 64;
        exp_alive = 24'hFFFFFC;
        exp_score = 20;

        // Bullet held inside enemy 2 for 10 cycles: exactly one kill.
        ifc.bullet_active = 1'b1;
        ifc.bullet_x      = 11'd198;
        ifc.bullet_y      = 11'd45;
        exp_alive[2]      = 1'b0;
        exp_score         = 30;
        for (int k = 0; k < 10; k++) begin
            step();
            check($sformatf("hold%0d hit", k),   32'(ifc.hit),   (k == 0) ? 32'd1 : 32'd0);
            check($sformatf("hold%0d alive", k), 32'(ifc.alive), 32'(exp_alive));
            check($sformatf("hold%0d score", k), 32'(ifc.score), 32'(exp_score));
        end
        ifc.bullet_active = 1'b0;
        step();

        // Down to 4 alive (row 2, cols 4..7): period 2.
        for (int i = 3; i < 20; i++) kill(i);
        check("four alive mask", 32'(ifc.alive), 32'h00F00000);
        frame(); check_pos("p2 f1");
        frame(); exp_bx = 68; check_pos("p2 f2");
        frame(); check_pos("p2 f3");
        frame(); exp_bx = 72; check_pos("p2 f4");

        // Asynchronous reset between clock edges.
        #2 reset = 1'b1;
        #1;
        check("async base_x", 32'(ifc.base_x), 32'd60);
        check("async base_y", 32'(ifc.base_y), 32'd40);
        check("async alive",  32'(ifc.alive),  32'h00FFFFFF);
        check("async score",  32'(ifc.score),  32'd0);
        do_reset();

        // Full grid: bounce at base_x=156, then march to the invasion line.
        n = 0;
        for (int f = 1; f <= 6000; f++) begin
            frame();
            n = f;
            if (f == 168) begin exp_bx = 156; exp_by = 40; check_pos("pre-bounce"); end
            if (f == 175) begin exp_bx = 156; exp_by = 56; check_pos("bounce");     end
            if (f == 182) begin exp_bx = 152; exp_by = 56; check_pos("after bounce"); end
            if (ifc.invaded) break;
        end
        check("invasion frame count", 32'(n), 32'd4375);
        check("invaded flag", 32'(ifc.invaded), 32'd1);
        check("invaded cleared", 32'(ifc.cleared), 32'd0);
        exp_bx = 0;
        exp_by = 296;
        check_pos("invaded");
        for (int k = 0; k < 14; k++) frame();
        check_pos("invaded frozen");
        ifc.bullet_active = 1'b1;
        ifc.bullet_x      = 11'd5;
        ifc.bullet_y      = 11'd300;
        step();
        step();
        check("invaded no hit",   32'(ifc.hit),   32'd0);
        check("invaded alive",    32'(ifc.alive), 32'h00FFFFFF);
        check("invaded score",    32'(ifc.score), 32'd0);
        ifc.bullet_active = 1'b0;

        // Kill coinciding with a move, then clear the grid.
        do_reset();
        for (int k = 0; k < 6; k++) frame();
        ifc.frame_start   = 1'b1;
        ifc.bullet_active = 1'b1;
        ifc.bullet_x      = 11'd70;
        ifc.bullet_y      = 11'd45;
        step();
        check("kill+move base_x", 32'(ifc.base_x), 32'd64);
        check("kill+move alive",  32'(ifc.alive),  32'h00FFFFFE);
        check("kill+move hit",    32'(ifc.hit),    32'd1);
        check("kill+move score",  32'(ifc.score),  32'd10);
        ifc.frame_start   = 1'b0;
        ifc.bullet_active = 1'b0;
        step();
        exp_bx       = 64;
        exp_alive[0] = 1'b0;
        exp_score    = 10;
        for (int i = 1; i < 24; i++) kill(i);
        check("cleared flag",    32'(ifc.cleared), 32'd1);
        check("cleared invaded", 32'(ifc.invaded), 32'd0);
        check("cleared alive",   32'(ifc.alive),   32'd0);
        check("cleared score",   32'(ifc.score),   32'd240);
        for (int k = 0; k < 8; k++) frame();
        check_pos("cleared frozen");
        check("cleared hit idle", 32'(ifc.hit), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
